// File: rtl/feed_ts_pkg.sv
// feed_ts_pkg: shared states, status codes and default widths for the latency probe path
package feed_ts_pkg;
    localparam int DEF_TS_W  = 64;
    localparam int DEF_LAT_W = 32;
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_NEG     = 2'd2;
    localparam logic [1:0] ST_SAT     = 2'd3;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ARMED, S_CAPTURE, S_REPORT} state_t;
endpackage

// File: rtl/latency_stats_acc.sv
// latency_stats_acc: running min/max/sum/count/error statistics; a clear beats a same-cycle update
module latency_stats_acc #(
    parameter int LAT_W = 32,
    parameter int SUM_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             upd_ok,
    input  logic             upd_err,
    input  logic [LAT_W-1:0] latency,
    output logic [31:0]      count,
    output logic [LAT_W-1:0] min,
    output logic [LAT_W-1:0] max,
    output logic [SUM_W-1:0] sum,
    output logic [31:0]      errors
);
    logic [SUM_W:0] sum_ext;
    always_comb sum_ext = {1'b0, sum} + {{(SUM_W+1-LAT_W){1'b0}}, latency};
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            count  <= '0;
            min    <= '1;
            max    <= '0;
            sum    <= '0;
            errors <= '0;
        end else if (clear) begin
            count  <= '0;
            min    <= '1;
            max    <= '0;
            sum    <= '0;
            errors <= '0;
        end else begin
            if (upd_ok) begin
                count <= &count ? count : count + 32'd1;
                min   <= latency < min ? latency : min;
                max   <= latency > max ? latency : max;
                sum   <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            end
            if (upd_err) errors <= &errors ? errors : errors + 32'd1;
        end
endmodule

// File: rtl/latency_probe_ctrl.sv
// latency_probe_ctrl: arms the TX/RX timestamp latch, waits for capture or timeout, reports rx-tx
module latency_probe_ctrl
    import feed_ts_pkg::*;
#(
    parameter int TS_W        = DEF_TS_W,
    parameter int LAT_W       = DEF_LAT_W,
    parameter int TIMEOUT_CYC = 65535,
    parameter int SUM_W       = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             ts_valid,
    input  logic [TS_W-1:0]  ts_tx,
    input  logic [TS_W-1:0]  ts_rx,
    output logic             ts_clear,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [LAT_W-1:0] res_latency,
    output logic [1:0]       res_status,
    input  logic             stat_clear,
    output logic [31:0]      stat_count,
    output logic [LAT_W-1:0] stat_min,
    output logic [LAT_W-1:0] stat_max,
    output logic [SUM_W-1:0] stat_sum,
    output logic [31:0]      stat_errors
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    state_t           state, state_n;
    logic [TW-1:0]    timer;
    logic [TS_W-1:0]  tx_q, rx_q, diff;
    logic             neg, sat, clr_n, upd_ok, upd_err;
    logic [LAT_W-1:0] lat_n;
    logic [1:0]       st_n;
    always_comb begin
        diff = rx_q - tx_q;
        neg  = rx_q < tx_q;
        sat  = |diff[TS_W-1:LAT_W];
    end
    always_comb begin
        state_n = state;
        clr_n   = 1'b0;
        upd_ok  = 1'b0;
        upd_err = 1'b0;
        lat_n   = '0;
        st_n    = ST_OK;
        case (state)
            S_IDLE:    if (start) state_n = S_CLEAR;
            S_CLEAR:   state_n = S_ARMED;
            S_ARMED:
                if (abort) begin
                    state_n = S_IDLE;
                    clr_n   = 1'b1;
                end else if (ts_valid) begin
                    state_n = S_CAPTURE;
                end else if (timer == TW'(TIMEOUT_CYC)) begin
                    state_n = S_REPORT;
                    upd_err = 1'b1;
                    st_n    = ST_TIMEOUT;
                end
            S_CAPTURE: begin
                state_n = S_REPORT;
                upd_ok  = !neg;
                upd_err = neg;
                st_n    = neg ? ST_NEG : sat ? ST_SAT : ST_OK;
                lat_n   = neg ? '0 : sat ? '1 : diff[LAT_W-1:0];
            end
            S_REPORT:
                if (res_ready) begin
                    state_n = S_IDLE;
                    clr_n   = 1'b1;
                end
            default:   state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= S_IDLE;
            ts_clear    <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_latency <= '0;
            res_status  <= ST_OK;
            timer       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
        end else begin
            state     <= state_n;
            ts_clear  <= clr_n || state_n == S_CLEAR;
            busy      <= state_n != S_IDLE;
            res_valid <= state_n == S_REPORT;
            timer     <= state == S_ARMED ? timer + TW'(1) : '0;
            if (state == S_ARMED && ts_valid) begin
                tx_q <= ts_tx;
                rx_q <= ts_rx;
            end
            if (upd_ok || upd_err) begin
                res_latency <= lat_n;
                res_status  <= st_n;
            end
        end
    latency_stats_acc #(.LAT_W(LAT_W), .SUM_W(SUM_W)) u_stats (
        .clk     (clk),
        .rst     (rst),
        .clear   (stat_clear),
        .upd_ok  (upd_ok),
        .upd_err (upd_err),
        .latency (lat_n),
        .count   (stat_count),
        .min     (stat_min),
        .max     (stat_max),
        .sum     (stat_sum),
        .errors  (stat_errors)
    );
endmodule
